// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key schedule constants, state encoding and GF(2^8) multiply
package aes_pkg;

  localparam int KEY_W  = 128;
  localparam int NUM_RK = 11;
  localparam int IDX_W  = 4;
  localparam int RND_W  = 4;

  // Index/round constants sized to their buses so comparisons stay width-exact.
  localparam logic [IDX_W-1:0] RK_COUNT = IDX_W'(NUM_RK);
  localparam logic [RND_W-1:0] LAST_RND = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  // FIPS-197 appendix A.1 reference key and selected round keys.
  localparam logic [KEY_W-1:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [KEY_W-1:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [KEY_W-1:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_key_schedule_store_if.sv
// rtl/aes_key_schedule_store_if.sv - key load / round-key read bus; zeroize present with AES_KS_ZEROIZE_EN
interface aes_key_schedule_store_if;
  import aes_pkg::*;

  logic [KEY_W-1:0] key_in;
  logic             key_valid;
  logic             key_ready;
  logic [IDX_W-1:0] rk_rd_idx;
  logic [KEY_W-1:0] rk_rd_data;
  logic             rk_rd_ok;
  logic             keys_ready;

`ifdef AES_KS_ZEROIZE_EN
  logic             zeroize;

  modport master (
    output key_in, key_valid, rk_rd_idx, zeroize,
    input  key_ready, rk_rd_data, rk_rd_ok, keys_ready
  );

  modport slave (
    input  key_in, key_valid, rk_rd_idx, zeroize,
    output key_ready, rk_rd_data, rk_rd_ok, keys_ready
  );
`else
  modport master (
    output key_in, key_valid, rk_rd_idx,
    input  key_ready, rk_rd_data, rk_rd_ok, keys_ready
  );

  modport slave (
    input  key_in, key_valid, rk_rd_idx,
    output key_ready, rk_rd_data, rk_rd_ok, keys_ready
  );
`endif

endinterface

// File: rtl/KeyGeneration.sv
// rtl/KeyGeneration.sv - combinational single-round AES-128 key expansion
module KeyGeneration
  import aes_pkg::*;
(
  input  logic [3:0]       roundcount,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] keyout
);

  // S-box as multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

  // Next round key: SubWord(RotWord(w3)) ^ Rcon folded through the four words.
  always_comb begin
    w0     = key[127:96];
    w1     = key[95:64];
    w2     = key[63:32];
    w3     = key[31:0];
    rot    = {w3[23:0], w3[31:24]};
    temp   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^
             {rcon(roundcount), 24'h000000};
    n0     = w0 ^ temp;
    n1     = w1 ^ n0;
    n2     = w2 ^ n1;
    n3     = w3 ^ n2;
    keyout = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_key_schedule_store.sv
// rtl/aes_key_schedule_store.sv - iterative AES-128 key schedule with 11-entry round-key store; zeroize with AES_KS_ZEROIZE_EN
module aes_key_schedule_store
  import aes_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  aes_key_schedule_store_if.slave  ks
);

  ks_state_e        state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [KEY_W-1:0] rk_q [NUM_RK];
  logic [KEY_W-1:0] rk_d [NUM_RK];
  logic [KEY_W-1:0] rd_data_q, rd_data_d;
  logic             rd_ok_q, rd_ok_d;
  logic [IDX_W-1:0] nprod;
  logic [KEY_W-1:0] kg_out;
  logic             zero;

`ifdef AES_KS_ZEROIZE_EN
  assign zero = ks.zeroize;
`else
  assign zero = 1'b0;
`endif

  // rnd_q only ever holds 0..9, so the expander never sees roundcount 10..15.
  KeyGeneration u_keygen (
    .roundcount (rnd_q),
    .key        (rk_q[rnd_q]),
    .keyout     (kg_out)
  );

  // Number of round keys already valid for the current key.
  always_comb begin
    nprod = '0;
    case (state_q)
      EXPAND:  nprod = rnd_q + 4'd1;
      DONE:    nprod = RK_COUNT;
      default: nprod = '0;
    endcase
  end

  // Next state, round counter, key store and read port; reads always see pre-edge contents.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    rk_d      = rk_q;
    rd_data_d = (ks.rk_rd_idx < RK_COUNT) ? rk_q[ks.rk_rd_idx] : '0;
    rd_ok_d   = (ks.rk_rd_idx < nprod);
    if (zero) begin
      state_d   = IDLE;
      rnd_d     = '0;
      for (int i = 0; i < NUM_RK; i++) rk_d[i] = '0;
      rd_data_d = '0;
      rd_ok_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (ks.key_valid) begin
            rk_d[0] = ks.key_in;
            rnd_d   = '0;
            state_d = EXPAND;
          end
        end
        EXPAND: begin
          rk_d[rnd_q + 4'd1] = kg_out;
          if (rnd_q == LAST_RND) begin
            state_d = DONE;
            rnd_d   = '0;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rnd_q     <= '0;
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
      rd_data_q <= '0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      rk_q      <= rk_d;
      rd_data_q <= rd_data_d;
      rd_ok_q   <= rd_ok_d;
    end
  end

  assign ks.key_ready  = (state_q == IDLE) || (state_q == DONE);
  assign ks.keys_ready = (state_q == DONE);
  assign ks.rk_rd_data = rd_data_q;
  assign ks.rk_rd_ok   = rd_ok_q;

endmodule
